// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
//   uart_state_e : transmitter frame state
//   LINE_IDLE    : level of an idle serial line
//   clk_max_f()  : clk cycles per line bit (integer division)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int clk_max_f(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fixed-rate bit timer: counts 0..CLK_MAX-1 and emits a one-cycle tick at the
// terminal count, then wraps.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (counter -> 0)
//   clr_i  : synchronous clear (counter -> 0)
//   tick_o : high during the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLK_MAX = 105
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_MAX < 2) ? 1 : $clog2(CLK_MAX);
  localparam logic [CW-1:0] TERM = CW'(CLK_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity,
// STOP_BITS stop bits. Bit timing derived from the system clock.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even when PARITY_ODD=0, odd when PARITY_ODD=1).
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset, aborts any frame
//   tx_data  : word to send, sampled on accept (tx_valid & tx_ready)
//   tx_valid : send request
//   tx_ready : idle, can accept a word this cycle
//   tx       : registered serial line, idle high
//   busy     : frame in progress (= !tx_ready)
module uart_tx import uart_pkg::*; #(
  parameter int CLK_RATE   = 12200000,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_MAX    = clk_max_f(CLK_RATE, BAUD_RATE),
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS + 2);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 accept;

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign tx       = tx_q;
  assign accept   = tx_valid & tx_ready;

  // Held clear while idle, so the first bit period starts at the accept edge.
  uart_baud_tick #(.CLK_MAX(CLK_MAX)) u_baud (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (tx_ready),
    .tick_o (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= (^tx_data) ^ PARITY_ODD[0];
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  // tx_d is the line value for the cycle after this edge, so tx stays a
  // flop output while changing exactly at bit boundaries.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (tick) begin
        if (bit_q == LAST_DATA) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = LINE_IDLE;
`endif
        end else begin
          bit_d   = bit_q + BW'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d    = LINE_IDLE;
      end
`endif
      STOP: if (tick) begin
        tx_d = LINE_IDLE;
        if (bit_q == LAST_STOP) begin
          state_d = IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = '0;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit counterpart to the team's baud-clocked UART receive path.
- Serialises a parallel word onto `tx` as start bit, DATA_BITS data bits LSB-first, optional parity bit, then STOP_BITS stop bits.
- Derives its own bit timing from the 12.2 MHz system clock; no external baud clock.
- Driven by on-chip logic, such as the SPI slave readout, to echo captured packets back over a pmod pin.

Parameters:
- CLK_RATE, 12200000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- CLK_MAX, CLK_RATE/BAUD_RATE (=105), clk cycles per bit (integer division); must be ≥2.
- DATA_BITS, 8, data bits per frame, range 5..16.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd); only meaningful with UART_TX_PARITY_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  word to send; sampled only on accept.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset (rst high at an edge): tx=1, tx_ready=1, busy=0, state=IDLE, bit counter=0, baud counter=0.
  - rst overrides everything, including a frame in progress.
  - A frame aborted mid-bit is truncated; tx is high on the cycle after the reset edge.
- Accept: an edge with tx_valid & tx_ready.
  - tx_data is latched into the shift register and the baud counter clears.
  - State goes to START; tx=0 and tx_ready=0 from the next cycle.
  - tx_valid while tx_ready=0 is ignored; no queueing. tx_data changes after accept have no effect.
- Bit timing:
  - The baud counter counts 0..CLK_MAX-1; each line bit lasts exactly CLK_MAX clk cycles.
  - A bit ends when the counter equals CLK_MAX-1; the counter then wraps to 0 and the next bit's value appears on tx the following cycle.
- States (tx value in each):
  - IDLE: tx=1.
  - START: tx=0, one bit time.
  - DATA: tx = shift[0], shifting right each bit; the bit counter counts DATA_BITS bits, then goes to PARITY if the feature is enabled, otherwise to STOP.
  - PARITY (feature only).
  - STOP: tx=1 for STOP_BITS bit times.
  - At the end of STOP, return to IDLE.
- Frame length F = 1 + DATA_BITS + P + STOP_BITS bits, where P = 1 with parity, else 0.
  - With accept at edge k, tx reflects the frame during cycles k+1 .. k+F·CLK_MAX.
  - tx_ready=1 again at cycle k+F·CLK_MAX+1.
  - Minimum start-to-start spacing of back-to-back frames is F·CLK_MAX+1 cycles; tx is guaranteed high between frames.
- busy = !tx_ready in all cases.
- Width rules:
  - Baud counter is $clog2(CLK_MAX) bits.
  - Bit counter is $clog2(DATA_BITS+2) bits.
  - No arithmetic overflow is permitted at the parameter extremes.

Optional Feature:
- UART_TX_PARITY_EN defined: PARITY state inserted after DATA.
  - tx = ^data_latched ^ PARITY_ODD, latched at accept, so even parity gives an even count of ones across data+parity.
  - F grows by 1.
- Not defined: no parity state or logic; PARITY_ODD is ignored; F = 1 + DATA_BITS + STOP_BITS.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam function for CLK_MAX;
  - line idle level (1'b1), also used by the receive path.
- One sub-module: uart_baud_tick.
  - Counter 0..CLK_MAX-1 with sync clear input; emits a one-cycle tick at terminal count.
  - Reusable as a fixed-rate replacement for the adaptive receive baud clock.

Test Plan:
- Reset, then idle 500 cycles → tx=1, tx_ready=1, busy=0 throughout.
- Send 8'h55, 8N1, CLK_MAX=105 → tx low for 105 cycles, then 1,0,1,0,1,0,1,0 for 105 cycles each, then high; tx_ready returns exactly 1051 cycles after accept.
- Back-to-back 8'hA5 then 8'h3C with tx_valid held high → second start bit begins 1051 cycles after the first; one idle-high cycle between frames; tx_valid pulses during busy are dropped.
- rst asserted mid-frame (after bit 3 of 8'hFF) → tx=1, tx_ready=1 next cycle; a fresh frame of 8'h00 afterwards is bit-exact.
- UART_TX_PARITY_EN, PARITY_ODD=0: 8'h07 → parity bit 1; 8'h03 → parity 0. PARITY_ODD=1: inverted. Frame is 11 bits (1156 cycles to ready).
- STOP_BITS=2, DATA_BITS=12, word 12'hABC → LSB-first 12 bits, stop high for 210 cycles, ready after 1576 cycles.
